// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one word load/store at a time,
// LATENCY wait states, STALL while busy, single-cycle DREADY completion pulse.
module dmem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        DREQ,
    input  logic        DRW,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    output logic [31:0] RDATA,
    output logic        DREADY,
    output logic        DERR,
    output logic        STALL
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0]  LAT      = 4'(LATENCY);
    localparam bit          ZERO_LAT = (LATENCY == 0);

    logic [31:0]           mem [DEPTH];

    state_t                state;
    logic [3:0]            cnt;
    logic                  lat_rw;
    logic                  lat_err;
    logic [DEPTH_LOG2-1:0] lat_idx;
    logic [31:0]           lat_wdata;

    logic                  req_err;
    logic [DEPTH_LOG2-1:0] req_idx;

    logic                  fire;
    logic                  acc_rw;
    logic                  acc_err;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic [31:0]           acc_wdata;

    always_comb begin
        req_err = (ADDR[1:0] != 2'b00) || (ADDR[31:DEPTH_LOG2+2] != '0);
        req_idx = ADDR[DEPTH_LOG2+1:2];
    end

    // With zero latency the access executes on the accepting edge, so it must
    // take the live request rather than the latched copy.
    always_comb begin
        fire      = 1'b0;
        acc_rw    = lat_rw;
        acc_err   = lat_err;
        acc_idx   = lat_idx;
        acc_wdata = lat_wdata;
        if (state == IDLE) begin
            acc_rw    = DRW;
            acc_err   = req_err;
            acc_idx   = req_idx;
            acc_wdata = WDATA;
            fire      = DREQ && ZERO_LAT;
        end else if (state == WAIT) begin
            fire      = (cnt == '0);
        end
    end

    always_comb begin
        STALL = !RST && (((state == IDLE) && DREQ) || (state == WAIT));
    end

    // Memory is deliberately not reset; a reset landing on the access edge drops the store.
    always_ff @(posedge CLK) begin
        if (fire && acc_rw && !acc_err && !RST) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            RDATA     <= '0;
            DREADY    <= 1'b0;
            DERR      <= 1'b0;
            lat_rw    <= 1'b0;
            lat_err   <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
        end else begin
            DREADY <= 1'b0;

            if (fire) begin
                DREADY <= 1'b1;
                DERR   <= acc_err;
                RDATA  <= (acc_rw || acc_err) ? '0 : mem[acc_idx];
            end

            case (state)
                IDLE: begin
                    if (DREQ) begin
                        lat_rw    <= DRW;
                        lat_err   <= req_err;
                        lat_idx   <= req_idx;
                        lat_wdata <= WDATA;
                        if (ZERO_LAT) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= LAT - 4'd1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    DERR  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
